// File: rtl/prog_sequencer_if.sv
// rtl/prog_sequencer_if.sv - host/datapath handshake and fetch-control bundle for prog_sequencer
interface prog_sequencer_if;
    logic        req;
    logic [1:0]  prog_sel;
    logic        halt;
    logic        abort;
    logic        ack;
    logic        fetch_reset;
    logic        fetch_start;
    logic        load_abs;
    logic [9:0]  load_target;
    logic        busy;
    logic        done;
    logic        timeout;
    logic        bad_sel;
    logic [15:0] cycle_count;
    logic [1:0]  state;

    modport slave (
        input  req, prog_sel, halt, abort, ack,
        output fetch_reset, fetch_start, load_abs, load_target,
               busy, done, timeout, bad_sel, cycle_count, state
    );

    modport master (
        output req, prog_sel, halt, abort, ack,
        input  fetch_reset, fetch_start, load_abs, load_target,
               busy, done, timeout, bad_sel, cycle_count, state
    );
endinterface

// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - launches one of three programs on the instruction fetcher and supervises its run
module prog_sequencer #(
    parameter logic [9:0]  START_ADDR0   = 10'h000,
    parameter logic [9:0]  START_ADDR1   = 10'h100,
    parameter logic [9:0]  START_ADDR2   = 10'h200,
    parameter logic [15:0] TIMEOUT_LIMIT = 16'd4000
) (
    input  logic            clk,
    input  logic            reset,
    prog_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cycle_count_q;
    logic [9:0]  load_target_q;
    logic [9:0]  start_addr;
    logic        timeout_q;
    logic        bad_sel_q;
    logic        abort_q;
    logic        launch, reject, aborting, halting, limit_hit;

    always_comb begin
        case (bus.prog_sel)
            2'd0:    start_addr = START_ADDR0;
            2'd1:    start_addr = START_ADDR1;
            default: start_addr = START_ADDR2;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Abort outranks halt, and halt outranks the run limit.
    always_comb begin
        state_d   = state_q;
        launch    = 1'b0;
        reject    = 1'b0;
        aborting  = 1'b0;
        halting   = 1'b0;
        limit_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    if (bus.prog_sel == 2'd3) begin
                        reject = 1'b1;
                    end else begin
                        launch  = 1'b1;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (bus.abort) begin
                    aborting = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    aborting = 1'b1;
                    state_d  = IDLE;
                end else if (bus.halt) begin
                    halting = 1'b1;
                    state_d = DONE;
                end else if (cycle_count_q >= TIMEOUT_LIMIT) begin
                    limit_hit = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (bus.ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count_q <= 16'd0;
            load_target_q <= 10'd0;
            timeout_q     <= 1'b0;
            bad_sel_q     <= 1'b0;
            abort_q       <= 1'b0;
        end else begin
            bad_sel_q <= reject;
            abort_q   <= aborting;
            if (launch) begin
                load_target_q <= start_addr;
                cycle_count_q <= 16'd0;
                timeout_q     <= 1'b0;
            end
            // Staying in RUN implies no abort, no halt and count below the limit.
            if (state_q == RUN && state_d == RUN)
                cycle_count_q <= cycle_count_q + 16'd1;
            if (aborting || halting)
                timeout_q <= 1'b0;
            else if (limit_hit)
                timeout_q <= 1'b1;
        end
    end

    assign bus.fetch_reset = reset | abort_q;
    assign bus.fetch_start = reset | (state_q == IDLE) | (state_q == DONE);
    assign bus.load_abs    = ~reset & (state_q == LOAD);
    assign bus.load_target = load_target_q;
    assign bus.busy        = (state_q == LOAD) | (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.timeout     = timeout_q;
    assign bus.bad_sel     = bad_sel_q;
    assign bus.cycle_count = cycle_count_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// tb/tb_prog_sequencer.sv - directed vector and corner-sequence bench for prog_sequencer
module tb_prog_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    prog_sequencer_if ifa ();
    prog_sequencer_if ifb ();

    prog_sequencer dut_a (.clk(clk), .reset(reset), .bus(ifa));
    prog_sequencer #(.TIMEOUT_LIMIT(16'd8)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    typedef struct {
        logic        rst, req;
        logic [1:0]  sel;
        logic        halt, abort, ack;
        logic [1:0]  st;
        logic        fr, fs, la, bs, to;
        logic [9:0]  lt;
        logic [15:0] cc;
    } vec_t;

    vec_t vt[23];

    function automatic vec_t mk(input logic rst, req, input logic [1:0] sel, input logic halt, abort, ack,
                                input logic [1:0] st, input logic fr, fs, la, bs, to,
                                input logic [9:0] lt, input logic [15:0] cc);
        vec_t v;
        v.rst = rst; v.req = req; v.sel = sel; v.halt = halt; v.abort = abort; v.ack = ack;
        v.st = st; v.fr = fr; v.fs = fs; v.la = la; v.bs = bs; v.to = to; v.lt = lt; v.cc = cc;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, req, input logic [1:0] sel, input logic halt, abort, ack);
        reset = rst;
        ifa.req = req; ifa.prog_sel = sel; ifa.halt = halt; ifa.abort = abort; ifa.ack = ack;
        ifb.req = req; ifb.prog_sel = sel; ifb.halt = halt; ifb.abort = abort; ifb.ack = ack;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            rst req sel halt abt ack  st fr fs la bs to  lt      cc
        vt[0]  = mk(1, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 10'h000, 0);   // reset
        vt[1]  = mk(0, 1, 3, 0, 0, 0,  0, 0, 1, 0, 1, 0, 10'h000, 0);   // illegal select
        vt[2]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 10'h000, 0);
        vt[3]  = mk(0, 1, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0, 10'h100, 0);   // launch prog 1
        vt[4]  = mk(0, 1, 2, 0, 0, 0,  2, 0, 0, 0, 0, 0, 10'h100, 0);   // req ignored in LOAD
        vt[5]  = mk(0, 0, 0, 0, 0, 1,  2, 0, 0, 0, 0, 0, 10'h100, 1);   // ack ignored in RUN
        vt[6]  = mk(0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0, 10'h100, 2);
        vt[7]  = mk(0, 0, 0, 1, 0, 0,  3, 0, 1, 0, 0, 0, 10'h100, 2);   // halt
        vt[8]  = mk(0, 1, 0, 0, 0, 0,  3, 0, 1, 0, 0, 0, 10'h100, 2);   // req ignored in DONE
        vt[9]  = mk(0, 0, 0, 0, 1, 0,  3, 0, 1, 0, 0, 0, 10'h100, 2);   // abort ignored in DONE
        vt[10] = mk(0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0, 10'h100, 2);   // ack
        vt[11] = mk(0, 1, 2, 0, 0, 0,  1, 0, 0, 1, 0, 0, 10'h200, 0);
        vt[12] = mk(0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0, 10'h200, 0);
        vt[13] = mk(0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0, 10'h200, 1);
        vt[14] = mk(0, 0, 0, 1, 1, 0,  0, 1, 1, 0, 0, 0, 10'h200, 1);   // abort beats halt
        vt[15] = mk(0, 0, 0, 0, 1, 0,  0, 0, 1, 0, 0, 0, 10'h200, 1);   // abort ignored in IDLE
        vt[16] = mk(0, 1, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 10'h000, 0);
        vt[17] = mk(0, 0, 0, 0, 1, 0,  0, 1, 1, 0, 0, 0, 10'h000, 0);   // abort in LOAD
        vt[18] = mk(0, 1, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0, 10'h100, 0);
        vt[19] = mk(0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0, 10'h100, 0);
        vt[20] = mk(0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0, 10'h100, 1);
        vt[21] = mk(1, 1, 1, 0, 0, 0,  0, 1, 1, 0, 0, 0, 10'h000, 0);   // reset mid-RUN with req
        vt[22] = mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 10'h000, 0);

        drive(1, 0, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 23; i++) begin
            drive(vt[i].rst, vt[i].req, vt[i].sel, vt[i].halt, vt[i].abort, vt[i].ack);
            step();
            chk("state",       i, ifa.state,       vt[i].st);
            chk("busy",        i, ifa.busy,        (vt[i].st == 2'd1 || vt[i].st == 2'd2));
            chk("done",        i, ifa.done,        (vt[i].st == 2'd3));
            chk("fetch_reset", i, ifa.fetch_reset, vt[i].fr);
            chk("fetch_start", i, ifa.fetch_start, vt[i].fs);
            chk("load_abs",    i, ifa.load_abs,    vt[i].la);
            chk("bad_sel",     i, ifa.bad_sel,     vt[i].bs);
            chk("timeout",     i, ifa.timeout,     vt[i].to);
            chk("load_target", i, ifa.load_target, vt[i].lt);
            chk("cycle_count", i, ifa.cycle_count, vt[i].cc);
        end

        // 25-cycle run on A; B runs into its limit of 8 on the same stimulus
        drive(0, 1, 0, 0, 0, 0);
        step();
        chk("seq_load_state", 0, ifa.state, 2'd1);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("seq_run_state", 0, ifa.state, 2'd2);
        chk("seq_run_cc", 0, ifa.cycle_count, 16'd0);
        for (int i = 1; i <= 25; i++) begin
            step();
            chk("a_cc", i, ifa.cycle_count, i);
            chk("a_state", i, ifa.state, 2'd2);
            chk("b_cc", i, ifb.cycle_count, (i > 8) ? 8 : i);
            chk("b_state", i, ifb.state, (i > 8) ? 2'd3 : 2'd2);
            chk("b_timeout", i, ifb.timeout, (i > 8));
        end
        drive(0, 0, 0, 1, 0, 0);
        step();
        chk("a_halt_state", 0, ifa.state, 2'd3);
        chk("a_halt_cc", 0, ifa.cycle_count, 16'd25);
        chk("a_halt_timeout", 0, ifa.timeout, 1'b0);
        chk("b_hold_timeout", 0, ifb.timeout, 1'b1);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("a_done_hold", i, ifa.done, 1'b1);
            chk("a_cc_hold", i, ifa.cycle_count, 16'd25);
        end
        drive(0, 0, 0, 0, 0, 1);
        step();
        chk("a_ack_state", 0, ifa.state, 2'd0);
        chk("b_ack_state", 0, ifb.state, 2'd0);
        chk("b_idle_timeout", 0, ifb.timeout, 1'b1);

        // Halt on the same edge the limit is reached: halt wins, no timeout
        drive(0, 1, 1, 0, 0, 0);
        step();
        chk("b_relaunch_timeout", 0, ifb.timeout, 1'b0);
        chk("b_relaunch_lt", 0, ifb.load_target, 10'h100);
        drive(0, 0, 0, 0, 0, 0);
        step();
        for (int i = 1; i <= 8; i++) step();
        chk("b_at_limit_cc", 0, ifb.cycle_count, 16'd8);
        chk("b_at_limit_state", 0, ifb.state, 2'd2);
        drive(0, 0, 0, 1, 0, 0);
        step();
        chk("b_tie_state", 0, ifb.state, 2'd3);
        chk("b_tie_timeout", 0, ifb.timeout, 1'b0);
        chk("b_tie_cc", 0, ifb.cycle_count, 16'd8);
        chk("a_halt8_cc", 0, ifa.cycle_count, 16'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
